// File: rtl/sobel_pkg.sv
// Shared widths, constants and helpers for the Sobel gradient-magnitude pipeline.
package sobel_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_COORD_W = 8;
    localparam int DEF_CNT_W   = 16;

    // 8-bit pixels: the largest weighted sum is 4*255 = 1020, and it needs 10 bits.
    // One more bit holds the sign of the difference.
    localparam int GRAD_W = 11;
    localparam int MAG_W  = 11;

    localparam logic [MAG_W-1:0]  SAT_MAX = MAG_W'(255);
    localparam logic [GRAD_W-1:0] W_SIDE  = GRAD_W'(1);
    localparam logic [GRAD_W-1:0] W_MID   = GRAD_W'(2);

    function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] r;
        r = g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
        return MAG_W'(r);
    endfunction

endpackage

// File: rtl/sobel_grad.sv
// Combinational weighted difference (a + 2b + c) - (d + 2e + f) for one Sobel axis.
module sobel_grad
    import sobel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0]        pos_side_a_i,
    input  logic [DATA_W-1:0]        pos_mid_i,
    input  logic [DATA_W-1:0]        pos_side_b_i,
    input  logic [DATA_W-1:0]        neg_side_a_i,
    input  logic [DATA_W-1:0]        neg_mid_i,
    input  logic [DATA_W-1:0]        neg_side_b_i,
    output logic signed [GRAD_W-1:0] grad_o
);

    logic [GRAD_W-1:0] pos_sum;
    logic [GRAD_W-1:0] neg_sum;

    // Zero-extended sums stay below 2^10. The modular subtraction therefore gives the exact signed result.
    always_comb begin
        pos_sum = GRAD_W'(pos_side_a_i) * W_SIDE
                + GRAD_W'(pos_mid_i)    * W_MID
                + GRAD_W'(pos_side_b_i) * W_SIDE;
        neg_sum = GRAD_W'(neg_side_a_i) * W_SIDE
                + GRAD_W'(neg_mid_i)    * W_MID
                + GRAD_W'(neg_side_b_i) * W_SIDE;
        grad_o  = $signed(pos_sum - neg_sum);
    end

endmodule

// File: rtl/sobel_kernel.sv
// Sobel gradient-magnitude pipeline: window register, gradient, magnitude, output.
// Tags, valid and end bits travel in lock-step with the data.
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int          DATA_W    = DEF_DATA_W,
    parameter int          COORD_W   = DEF_COORD_W,
    parameter int unsigned THRESHOLD = 0,
    parameter int          CNT_W     = DEF_CNT_W
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Enable,
    input  logic               isReady,
    input  logic               isEnd,
    input  logic [DATA_W-1:0]  DataIn0,
    input  logic [DATA_W-1:0]  DataIn1,
    input  logic [DATA_W-1:0]  DataIn2,
    input  logic [DATA_W-1:0]  DataIn3,
    input  logic [DATA_W-1:0]  DataIn4,
    input  logic [DATA_W-1:0]  DataIn5,
    input  logic [DATA_W-1:0]  DataIn6,
    input  logic [DATA_W-1:0]  DataIn7,
    input  logic [DATA_W-1:0]  DataIn8,
    input  logic [COORD_W-1:0] In_Row,
    input  logic [COORD_W-1:0] In_Column,
    output logic [DATA_W-1:0]  PixelOut,
    output logic [COORD_W-1:0] Out_Row,
    output logic [COORD_W-1:0] Out_Column,
    output logic               OutValid,
    output logic               isDone,
    output logic [CNT_W-1:0]   OutCount
);

    localparam logic [MAG_W-1:0] THR = MAG_W'(THRESHOLD);

    // Window stage
    logic [DATA_W-1:0]  d0_q, d1_q, d2_q, d3_q, d4_q, d5_q, d6_q, d7_q, d8_q;
    logic               v0_q, e0_q;
    logic [COORD_W-1:0] row0_q, col0_q;
    logic [COORD_W-1:0] row0_d, col0_d;

    // Gradient stage
    logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
    logic                     v1_q, e1_q;
    logic [COORD_W-1:0]       row1_q, col1_q;

    // Magnitude stage
    logic [MAG_W-1:0]   mag_d, mag_q;
    logic               v2_q, e2_q;
    logic [COORD_W-1:0] row2_q, col2_q;

    // Output stage
    logic [DATA_W-1:0]  pix_d, pix_q;
    logic               v3_q, e3_q;
    logic [COORD_W-1:0] row3_q, col3_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;

    sobel_grad #(.DATA_W(DATA_W)) u_grad_x (
        .pos_side_a_i (d2_q),
        .pos_mid_i    (d5_q),
        .pos_side_b_i (d8_q),
        .neg_side_a_i (d0_q),
        .neg_mid_i    (d3_q),
        .neg_side_b_i (d6_q),
        .grad_o       (gx_d)
    );

    sobel_grad #(.DATA_W(DATA_W)) u_grad_y (
        .pos_side_a_i (d6_q),
        .pos_mid_i    (d7_q),
        .pos_side_b_i (d8_q),
        .neg_side_a_i (d0_q),
        .neg_mid_i    (d1_q),
        .neg_side_b_i (d2_q),
        .grad_o       (gy_d)
    );

    always_comb begin
        row0_d = isReady ? In_Row    : row0_q;
        col0_d = isReady ? In_Column : col0_q;
        mag_d  = abs_grad(gx_q) + abs_grad(gy_q);
        if (THRESHOLD == 0) begin
            pix_d = (mag_q > SAT_MAX) ? DATA_W'(SAT_MAX) : mag_q[DATA_W-1:0];
        end else begin
            pix_d = (mag_q >= THR) ? DATA_W'(SAT_MAX) : '0;
        end
        cnt_d = cnt_q + CNT_W'(v2_q);
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            d0_q   <= '0; d1_q <= '0; d2_q <= '0;
            d3_q   <= '0; d4_q <= '0; d5_q <= '0;
            d6_q   <= '0; d7_q <= '0; d8_q <= '0;
            v0_q   <= 1'b0;
            e0_q   <= 1'b0;
            row0_q <= '0;
            col0_q <= '0;
            gx_q   <= '0;
            gy_q   <= '0;
            v1_q   <= 1'b0;
            e1_q   <= 1'b0;
            row1_q <= '0;
            col1_q <= '0;
            mag_q  <= '0;
            v2_q   <= 1'b0;
            e2_q   <= 1'b0;
            row2_q <= '0;
            col2_q <= '0;
            pix_q  <= '0;
            v3_q   <= 1'b0;
            e3_q   <= 1'b0;
            row3_q <= '0;
            col3_q <= '0;
            cnt_q  <= '0;
        end else if (Enable) begin
            d0_q   <= DataIn0; d1_q <= DataIn1; d2_q <= DataIn2;
            d3_q   <= DataIn3; d4_q <= DataIn4; d5_q <= DataIn5;
            d6_q   <= DataIn6; d7_q <= DataIn7; d8_q <= DataIn8;
            v0_q   <= isReady;
            e0_q   <= isReady & isEnd;
            row0_q <= row0_d;
            col0_q <= col0_d;
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            v1_q   <= v0_q;
            e1_q   <= e0_q;
            row1_q <= row0_q;
            col1_q <= col0_q;
            mag_q  <= mag_d;
            v2_q   <= v1_q;
            e2_q   <= e1_q;
            row2_q <= row1_q;
            col2_q <= col1_q;
            pix_q  <= pix_d;
            v3_q   <= v2_q;
            e3_q   <= e2_q;
            row3_q <= row2_q;
            col3_q <= col2_q;
            cnt_q  <= cnt_d;
        end
    end

    // The centre pixel carries no Sobel weight; it is registered only to keep the window intact.
    logic unused_centre;
    assign unused_centre = ^d4_q;

    assign PixelOut   = pix_q;
    assign Out_Row    = row3_q;
    assign Out_Column = col3_q;
    assign OutValid   = v3_q;
    assign isDone     = e3_q;
    assign OutCount   = cnt_q;

endmodule
